// File: rtl/ldl_max_window_pkg.sv
// Shared types and constants for the windowed running-maximum controller.
package ldl_max_window_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_FLUSH = 2'd2
   } state_t;

   // A programmed length of zero arms a window of this many samples.
   localparam int unsigned LEN_ZERO_MAP = 1;

endpackage

// File: rtl/ldl_max_track.sv
// Running-maximum tracker: holds the current peak and the index of its first occurrence.
module ldl_max_track #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear_i,
   input  logic             accept_i,
   input  logic             first_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic [CNT_W-1:0] idx_i,
   output logic [WIDTH-1:0] max_o,
   output logic [CNT_W-1:0] idx_o,
   output logic [WIDTH-1:0] nxt_max_o,
   output logic [CNT_W-1:0] nxt_idx_o
);

   logic [WIDTH-1:0] max_q, max_d;
   logic [CNT_W-1:0] idx_q, idx_d;
   logic             take;

   // Strict compare so a tie keeps the earlier index; the first sample always loads.
   assign take      = accept_i & (first_i | (data_i > max_q));
   assign nxt_max_o = take ? data_i : max_q;
   assign nxt_idx_o = take ? idx_i  : idx_q;

   always_comb begin
      max_d = nxt_max_o;
      idx_d = nxt_idx_o;
      if (clear_i) begin
         max_d = '0;
         idx_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         max_q <= '0;
         idx_q <= '0;
      end else begin
         max_q <= max_d;
         idx_q <= idx_d;
      end
   end

   assign max_o = max_q;
   assign idx_o = idx_q;

endmodule

// File: rtl/ldl_max_window_ctrl.sv
// Windowed peak finder: counts samples per window, emits (max, idx) per window,
// supports continuous re-arm and flushing of aborted partial windows.
module ldl_max_window_ctrl
   import ldl_max_window_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             stop,
   input  logic             cont,
   input  logic [CNT_W-1:0] cfg_len,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_max,
   output logic [CNT_W-1:0] out_idx,
   output logic             out_partial,
   output logic             busy
);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] len_q, len_d;
   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] out_max_q, out_max_d;
   logic [CNT_W-1:0] out_idx_q, out_idx_d;
   logic             out_partial_q, out_partial_d;

   logic             accept, last, trk_clear;
   logic [WIDTH-1:0] trk_max, trk_nxt_max;
   logic [CNT_W-1:0] trk_idx, trk_nxt_idx;

   // Ready depends only on registered state and the consumer, never on in_valid.
   assign in_ready = (state_q == ST_RUN) & (~out_valid_q | out_ready);
   assign accept   = in_valid & in_ready;
   assign last     = accept & (cnt_q == (len_q - CNT_W'(1)));

   ldl_max_track #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_track (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear_i   (trk_clear),
      .accept_i  (accept),
      .first_i   (cnt_q == '0),
      .data_i    (in_data),
      .idx_i     (cnt_q),
      .max_o     (trk_max),
      .idx_o     (trk_idx),
      .nxt_max_o (trk_nxt_max),
      .nxt_idx_o (trk_nxt_idx)
   );

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      len_d         = len_q;
      out_valid_d   = out_valid_q & ~out_ready;
      out_max_d     = out_max_q;
      out_idx_d     = out_idx_q;
      out_partial_d = out_partial_q;
      trk_clear     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start && !stop) begin
               state_d   = ST_RUN;
               len_d     = (cfg_len == '0) ? CNT_W'(LEN_ZERO_MAP) : cfg_len;
               cnt_d     = '0;
               trk_clear = 1'b1;
            end
         end
         ST_RUN: begin
            if (accept) cnt_d = cnt_q + CNT_W'(1);
            if (last) begin
               out_max_d     = trk_nxt_max;
               out_idx_d     = trk_nxt_idx;
               out_partial_d = 1'b0;
               out_valid_d   = 1'b1;
               cnt_d         = '0;
               state_d       = (cont && !stop) ? ST_RUN : ST_IDLE;
            end else if (stop) begin
               // An empty window aborts silently; anything collected is flushed.
               state_d = (cnt_q == '0 && !accept) ? ST_IDLE : ST_FLUSH;
            end
         end
         ST_FLUSH: begin
            if (!out_valid_q || out_ready) begin
               out_max_d     = trk_max;
               out_idx_d     = trk_idx;
               out_partial_d = 1'b1;
               out_valid_d   = 1'b1;
               state_d       = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         cnt_q         <= '0;
         len_q         <= '0;
         out_valid_q   <= 1'b0;
         out_max_q     <= '0;
         out_idx_q     <= '0;
         out_partial_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         len_q         <= len_d;
         out_valid_q   <= out_valid_d;
         out_max_q     <= out_max_d;
         out_idx_q     <= out_idx_d;
         out_partial_q <= out_partial_d;
      end
   end

   assign out_valid   = out_valid_q;
   assign out_max     = out_max_q;
   assign out_idx     = out_idx_q;
   assign out_partial = out_partial_q;
   assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ldl_max_window_ctrl.sv
// Directed bench for ldl_max_window_ctrl: one-shot, continuous, back-pressure, flush, len=0 and reset.
module tb_ldl_max_window_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic       stop = 1'b0;
   logic       cont = 1'b0;
   logic [7:0] cfg_len = 8'd0;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [7:0] in_data = 8'd0;
   logic       out_valid;
   logic       out_ready = 1'b1;
   logic [7:0] out_max;
   logic [7:0] out_idx;
   logic       out_partial;
   logic       busy;

   typedef struct packed {
      logic [7:0] mx;
      logic [7:0] ix;
      logic       pt;
   } res_t;

   res_t res_q[$];
   int   total = 0;
   int   passed = 0;

   ldl_max_window_ctrl #(.WIDTH(8), .CNT_W(8)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .stop        (stop),
      .cont        (cont),
      .cfg_len     (cfg_len),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_data     (in_data),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_max     (out_max),
      .out_idx     (out_idx),
      .out_partial (out_partial),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   // Record every result handshake that will complete at the next rising edge.
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) res_q.push_back('{out_max, out_idx, out_partial});
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Offer one sample and wait until it is accepted; returns cycles spent.
   task automatic send(input logic [7:0] d, output int cyc);
      in_valid = 1'b1;
      in_data  = d;
      cyc = 0;
      while (!in_ready && cyc < 20) begin
         step();
         cyc++;
      end
      if (in_ready) begin
         step();
         cyc++;
      end else begin
         chk("send_timeout", 32'd0, 32'd1);
      end
   endtask

   task automatic arm(input logic [7:0] len, input logic c);
      cfg_len = len;
      cont    = c;
      start   = 1'b1;
      step();
      start   = 1'b0;
   endtask

   task automatic pulse_stop();
      stop = 1'b1;
      step();
      stop = 1'b0;
   endtask

   task automatic expect_res(input string tag, input logic [7:0] m, input logic [7:0] i, input logic p);
      res_t r;
      int   w = 0;
      while (res_q.size() == 0 && w < 20) begin
         step();
         w++;
      end
      if (res_q.size() == 0) begin
         chk({tag, "_timeout"}, 32'd0, 32'd1);
      end else begin
         r = res_q.pop_front();
         chk({tag, "_max"}, 32'(r.mx), 32'(m));
         chk({tag, "_idx"}, 32'(r.ix), 32'(i));
         chk({tag, "_partial"}, 32'(r.pt), 32'(p));
      end
   endtask

   initial begin
      int c;
      int cyc_sum;
      logic [7:0] d6 [6];

      #2;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_out_max", 32'(out_max), 32'd0);
      step();
      rst_n = 1'b1;
      step();

      // start together with stop must not arm
      start = 1'b1; stop = 1'b1; cfg_len = 8'd4;
      step();
      start = 1'b0; stop = 1'b0;
      chk("startstop_busy", 32'(busy), 32'd0);

      // 1: one-shot len=4
      arm(8'd4, 1'b0);
      chk("t1_busy", 32'(busy), 32'd1);
      send(8'd3, c); send(8'd9, c); send(8'd2, c); send(8'd9, c);
      in_valid = 1'b0;
      chk("t1_out_valid", 32'(out_valid), 32'd1);
      chk("t1_busy_after", 32'(busy), 32'd0);
      chk("t1_in_ready_after", 32'(in_ready), 32'd0);
      expect_res("t1", 8'd9, 8'd1, 1'b0);

      // 2: continuous len=3, full throughput
      arm(8'd3, 1'b1);
      d6[0] = 8'd1; d6[1] = 8'd5; d6[2] = 8'd2; d6[3] = 8'd7; d6[4] = 8'd0; d6[5] = 8'd7;
      cyc_sum = 0;
      for (int k = 0; k < 6; k++) begin
         send(d6[k], c);
         cyc_sum += c;
      end
      in_valid = 1'b0;
      chk("t2_cycles", 32'(cyc_sum), 32'd6);
      expect_res("t2a", 8'd5, 8'd1, 1'b0);
      expect_res("t2b", 8'd7, 8'd0, 1'b0);
      cont = 1'b0;
      pulse_stop();
      chk("t2_idle", 32'(busy), 32'd0);

      // 3: len=2 continuous, consumer stalls on second result
      arm(8'd2, 1'b1);
      send(8'd5, c); send(8'd3, c);
      in_valid = 1'b0;
      step();
      expect_res("t3a", 8'd5, 8'd0, 1'b0);
      out_ready = 1'b0;
      send(8'd4, c); send(8'd8, c);
      in_valid = 1'b0;
      for (int k = 0; k < 3; k++) begin
         chk("t3_hold_valid", 32'(out_valid), 32'd1);
         chk("t3_hold_max", 32'(out_max), 32'd8);
         chk("t3_hold_idx", 32'(out_idx), 32'd1);
         chk("t3_in_ready", 32'(in_ready), 32'd0);
         step();
      end
      chk("t3_no_early_res", 32'(res_q.size()), 32'd0);
      out_ready = 1'b1;
      expect_res("t3b", 8'd8, 8'd1, 1'b0);
      step();
      cont = 1'b0;
      pulse_stop();
      chk("t3_idle", 32'(busy), 32'd0);

      // 4: abort after two samples of five
      arm(8'd5, 1'b0);
      send(8'd4, c); send(8'd6, c);
      in_valid = 1'b0;
      pulse_stop();
      chk("t4_flush_busy", 32'(busy), 32'd1);
      chk("t4_flush_in_ready", 32'(in_ready), 32'd0);
      step();
      chk("t4_out_valid", 32'(out_valid), 32'd1);
      chk("t4_busy_after", 32'(busy), 32'd0);
      expect_res("t4", 8'd6, 8'd1, 1'b1);

      // 5: cfg_len=0 behaves as length 1
      arm(8'd0, 1'b1);
      send(8'd8, c);
      chk("t5_first_valid", 32'(out_valid), 32'd1);
      send(8'd3, c);
      in_valid = 1'b0;
      expect_res("t5a", 8'd8, 8'd0, 1'b0);
      expect_res("t5b", 8'd3, 8'd0, 1'b0);
      cont = 1'b0;
      pulse_stop();
      chk("t5_idle", 32'(busy), 32'd0);

      // 6: asynchronous reset mid-window
      arm(8'd4, 1'b0);
      send(8'd1, c); send(8'd2, c);
      in_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      chk("t6_rst_busy", 32'(busy), 32'd0);
      chk("t6_rst_out_valid", 32'(out_valid), 32'd0);
      step();
      rst_n = 1'b1;
      step();
      chk("t6_no_result", 32'(res_q.size()), 32'd0);
      arm(8'd2, 1'b0);
      send(8'd1, c); send(8'd2, c);
      in_valid = 1'b0;
      expect_res("t6", 8'd2, 8'd1, 1'b0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
